// File: rtl/resonator_dds_mul_arbiter.sv
`default_nettype none
// =============================================================================
// resonator_dds_mul_arbiter - round-robin sharing of one 2-stage signed
// multiplier among NUM_REQ DDS scaling lanes, with tagged one-hot responses.
// Revision: 1.0
// =============================================================================
module resonator_dds_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int A_WIDTH     = 17,
  parameter int B_WIDTH     = 16,
  parameter int P_WIDTH     = A_WIDTH + B_WIDTH,
  parameter int MUL_LATENCY = 2,
  parameter int ID_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         mul_ce,
  output logic [A_WIDTH-1:0]           mul_din0,
  output logic [B_WIDTH-1:0]           mul_din1,
  input  logic [P_WIDTH-1:0]           mul_dout,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [P_WIDTH-1:0]           rsp_p,
  output logic [ID_WIDTH+1:0]          inflight
);

  localparam int                  LAST    = MUL_LATENCY;
  localparam logic [ID_WIDTH:0]   NREQ_W  = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] grant_id;
  logic                grant_found;
  logic                accept;
  logic [ID_WIDTH:0]   cand;
  logic [A_WIDTH-1:0]  sel_a;
  logic [B_WIDTH-1:0]  sel_b;

  // Tag stage 0 sits beside the operand registers; the rest track the multiplier.
  logic [MUL_LATENCY:0] tag_v;
  logic [ID_WIDTH-1:0]  tag_id [0:MUL_LATENCY];

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, rr_ptr} + (ID_WIDTH+1)'(off);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!grant_found && req_valid[cand[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[ID_WIDTH-1:0];
      end
    end
  end

  assign accept = grant_found & ce & ~reset;

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        sel_a        = req_a[i*A_WIDTH +: A_WIDTH];
        sel_b        = req_b[i*B_WIDTH +: B_WIDTH];
        req_ready[i] = accept;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      mul_din0 <= '0;
      mul_din1 <= '0;
      tag_v    <= '0;
      for (int s = 0; s <= MUL_LATENCY; s++) tag_id[s] <= '0;
      inflight <= '0;
    end else if (ce) begin
      tag_v <= {tag_v[MUL_LATENCY-1:0], accept};
      for (int s = 1; s <= MUL_LATENCY; s++) tag_id[s] <= tag_id[s-1];
      if (accept) begin
        mul_din0  <= sel_a;
        mul_din1  <= sel_b;
        tag_id[0] <= grant_id;
        rr_ptr    <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end
      // Simultaneous accept and retire leaves the count unchanged.
      if (accept && !tag_v[LAST])
        inflight <= inflight + 1'b1;
      else if (!accept && tag_v[LAST])
        inflight <= inflight - 1'b1;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_rsp
      assign rsp_valid[i] = tag_v[LAST] && (tag_id[LAST] == ID_WIDTH'(i)) && !reset;
    end
  endgenerate

  assign mul_ce = ce;
  assign rsp_id = tag_id[LAST];
  assign rsp_p  = mul_dout;

endmodule
`default_nettype wire

// File: tb/tb_resonator_dds_mul_arbiter.sv
`default_nettype none
// =============================================================================
// tb_resonator_dds_mul_arbiter - directed self-checking bench with a 2-stage
// ce-gated multiplier model feeding mul_dout. Revision: 1.0
// =============================================================================
module tb_resonator_dds_mul_arbiter;

  localparam int N  = 4;
  localparam int AW = 17;
  localparam int BW = 16;
  localparam int PW = 33;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            ce;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic            mul_ce;
  logic [AW-1:0]   mul_din0;
  logic [BW-1:0]   mul_din1;
  logic [PW-1:0]   mul_dout;
  logic [N-1:0]    rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [PW-1:0]   rsp_p;
  logic [IW+1:0]   inflight;

  int passed = 0;
  int total  = 0;

  resonator_dds_mul_arbiter dut (
    .clk(clk), .reset(reset), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // External multiplier: two ce-gated register stages, no reset.
  logic signed [PW-1:0] m1 = '0;
  logic signed [PW-1:0] m2 = '0;
  always @(posedge clk) begin
    if (mul_ce) begin
      m1 <= PW'($signed(mul_din0) * $signed(mul_din1));
      m2 <= m1;
    end
  end
  assign mul_dout = m2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*AW +: AW] = AW'(a);
    req_b[i*BW +: BW] = BW'(b);
  endtask

  task automatic chk_rsp(input string tag, input longint v, input longint id, input longint p);
    chk({tag, "_valid"}, longint'(rsp_valid), v);
    if (v != 0) begin
      chk({tag, "_id"}, longint'(rsp_id), id);
      chk({tag, "_p"}, longint'($signed(rsp_p)), p);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; req_valid = '0; req_a = '0; req_b = '0;

    // Reset state: valid requester must not be granted while reset is high.
    req_valid = 4'b0001;
    settle();
    chk("rst_ready", longint'(req_ready), 0);
    chk("rst_rsp_valid", longint'(rsp_valid), 0);
    chk("rst_inflight", longint'(inflight), 0);
    chk("rst_din0", longint'(mul_din0), 0);
    chk("rst_rsp_id", longint'(rsp_id), 0);
    req_valid = '0;
    tick();
    reset = 1'b0;
    tick();

    // Single op: 100 * -3
    set_op(0, 100, -3);
    req_valid = 4'b0001;
    settle();
    chk("single_ready", longint'(req_ready), 4'b0001);
    tick();
    req_valid = '0;
    settle();
    chk("single_din0", longint'($signed(mul_din0)), 100);
    chk("single_din1", longint'($signed(mul_din1)), -3);
    chk("single_infl1", longint'(inflight), 1);
    chk_rsp("single_c2", 0, 0, 0);
    tick();
    chk("single_infl2", longint'(inflight), 1);
    chk_rsp("single_c3", 0, 0, 0);
    tick();
    chk_rsp("single_c4", 4'b0001, 0, -300);
    chk("single_infl3", longint'(inflight), 1);
    tick();
    chk_rsp("single_c5", 0, 0, 0);
    chk("single_infl4", longint'(inflight), 0);

    // Extremes from requester 2, back-to-back (rr_ptr is 1 here).
    set_op(2, -65536, -32768);
    req_valid = 4'b0100;
    settle();
    chk("ext_ready1", longint'(req_ready), 4'b0100);
    tick();
    set_op(2, 65535, 32767);
    settle();
    chk("ext_ready2", longint'(req_ready), 4'b0100);
    tick();
    req_valid = '0;
    settle();
    chk("ext_infl", longint'(inflight), 2);
    tick();
    chk_rsp("ext_neg", 4'b0100, 2, 64'sd2147483648);
    chk("ext_infl_b", longint'(inflight), 2);
    tick();
    chk_rsp("ext_pos", 4'b0100, 2, 64'sd2147385345);
    chk("ext_infl_c", longint'(inflight), 1);
    tick();
    chk_rsp("ext_done", 0, 0, 0);
    chk("ext_infl_d", longint'(inflight), 0);

    // Round-robin with all four requesters valid from rr_ptr = 0.
    pulse_reset();
    for (int i = 0; i < N; i++) set_op(i, i + 1, 10);
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      settle();
      chk("rr_ready", longint'(req_ready), (c < 8) ? (longint'(1) << (c % 4)) : 0);
      if (c >= 3)
        chk_rsp("rr_rsp", longint'(1) << ((c - 3) % 4), (c - 3) % 4, 10 * ((c - 3) % 4 + 1));
      else
        chk_rsp("rr_rsp_early", 0, 0, 0);
      if (c == 5) chk("rr_infl_full", longint'(inflight), 3);
      tick();
    end
    chk_rsp("rr_drain", 0, 0, 0);
    chk("rr_infl_end", longint'(inflight), 0);

    // Skip/wrap: grant 1 moves rr_ptr to 2, then only 1 and 3 compete.
    req_valid = 4'b0010;
    settle();
    chk("skip_ready0", longint'(req_ready), 4'b0010);
    tick();
    req_valid = 4'b1010;
    settle();
    chk("skip_ready1", longint'(req_ready), 4'b1000);
    tick();
    chk("skip_ready2", longint'(req_ready), 4'b0010);
    tick();
    chk("skip_ready3", longint'(req_ready), 4'b1000);
    chk_rsp("skip_rsp0", 4'b0010, 1, 20);
    tick();
    req_valid = '0;
    settle();
    chk_rsp("skip_rsp1", 4'b1000, 3, 40);
    tick();
    chk_rsp("skip_rsp2", 4'b0010, 1, 20);
    tick();
    chk_rsp("skip_rsp3", 4'b1000, 3, 40);
    tick();
    chk_rsp("skip_rsp4", 0, 0, 0);

    // ce stall after accepting 7 * 7 (rr_ptr wrapped to 0).
    set_op(0, 7, 7);
    req_valid = 4'b0001;
    settle();
    chk("stall_ready", longint'(req_ready), 4'b0001);
    tick();
    ce = 1'b0;
    for (int s = 0; s < 5; s++) begin
      settle();
      chk("stall_ready_off", longint'(req_ready), 0);
      chk("stall_rsp", longint'(rsp_valid), 0);
      chk("stall_infl", longint'(inflight), 1);
      chk("stall_mul_ce", longint'(mul_ce), 0);
      tick();
    end
    req_valid = '0;
    ce = 1'b1;
    settle();
    chk_rsp("stall_c1", 0, 0, 0);
    tick();
    chk_rsp("stall_c2", 0, 0, 0);
    tick();
    chk_rsp("stall_c3", 4'b0001, 0, 49);
    tick();
    chk("stall_infl_end", longint'(inflight), 0);

    // Reset mid-flight with three ops outstanding (rr_ptr = 1).
    set_op(3, -1234, 567);
    req_valid = 4'b0111;
    tick();
    tick();
    tick();
    req_valid = '0;
    settle();
    chk("mid_infl_pre", longint'(inflight), 3);
    reset = 1'b1;
    settle();
    chk("mid_rsp_rst", longint'(rsp_valid), 0);
    chk("mid_infl_rst", longint'(inflight), 0);
    tick();
    reset = 1'b0;
    req_valid = 4'b1000;
    settle();
    chk("mid_ready3", longint'(req_ready), 4'b1000);
    chk("mid_rsp_a", longint'(rsp_valid), 0);
    tick();
    req_valid = '0;
    settle();
    chk("mid_rsp_b", longint'(rsp_valid), 0);
    chk("mid_infl1", longint'(inflight), 1);
    tick();
    chk("mid_rsp_c", longint'(rsp_valid), 0);
    tick();
    chk_rsp("mid_rsp3", 4'b1000, 3, -699678);
    tick();
    chk_rsp("mid_done", 0, 0, 0);
    chk("mid_infl_end", longint'(inflight), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
